// File: rtl/ppcpu_pkg.sv
// ppcpu_pkg: shared pipeline definitions.
// Holds the fetch queue defaults (reset PC, depth), the fetch controller
// state encodings and the queue entry layout.
package ppcpu_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          DEF_FQ_DEPTH = 4;

  // Fetch controller states (kept as plain constants for legacy users)
  localparam logic [1:0] S_IDLE = 2'd0;  // no request outstanding
  localparam logic [1:0] S_WAIT = 2'd1;  // request out, response wanted
  localparam logic [1:0] S_DROP = 2'd2;  // request out, response discarded

  // One queue entry: 96 bits
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } fq_entry_t;

  // Sequential fetch address; 32-bit wrap is intentional
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory bus and fetch->decode channel.
//   MemReq/MemAddr  : read request, held until MemAck
//   MemAck/MemData  : one-cycle completion with instruction word
//   F_Valid/F_PC/F_PC4/F_Inst : queue head toward IF_ID
//   D_Ready         : decode accepts the head this cycle
// master = fetch queue side, slave = memory/decode side.
interface fetch_queue_if;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemData;
  logic        F_Valid;
  logic [31:0] F_PC;
  logic [31:0] F_PC4;
  logic [31:0] F_Inst;
  logic        D_Ready;

  modport master (
    output MemReq, MemAddr, F_Valid, F_PC, F_PC4, F_Inst,
    input  MemAck, MemData, D_Ready
  );

  modport slave (
    input  MemReq, MemAddr, F_Valid, F_PC, F_PC4, F_Inst,
    output MemAck, MemData, D_Ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of fetched {pc, pc4, inst} entries.
// Ports:
//   clk, rst        : clock, async active-high reset
//   i_push, i_din   : write entry at tail
//   i_pop           : advance head (ignored when empty)
//   i_flush         : empty the queue; wins over push/pop
//   o_head, o_valid : head entry (zero when empty) and non-empty flag
//   o_count         : occupied entries, 0..DEPTH
module fetch_fifo
  import ppcpu_pkg::*;
#(
  parameter int DEPTH = DEF_FQ_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_flush,
  input  fq_entry_t   i_din,
  output fq_entry_t   o_head,
  output logic        o_valid,
  output logic [AW:0] o_count
);

  fq_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0]   r_count;
  logic          w_push, w_pop;

  // Full-guard is belt-and-braces; the controller never issues when full
  assign w_push = i_push && (r_count != (AW+1)'(DEPTH));
  assign w_pop  = i_pop  && (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;  // power-of-two wrap
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Data array needs no reset: outputs are masked while empty
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_tail] <= i_din;
  end

  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_mem[r_head] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch controller plus decoupling queue.
// Ports:
//   CLK, RST    : clock, async active-high reset
//   Redirect    : taken branch/jump pulse from MEM
//   RedirTarget : new fetch address (low 2 bits dropped)
//   bus         : memory request/response and head-of-queue channel
//   QCount      : queue occupancy
// One request at a time; a slot is reserved before issue, so a returning
// word always has room. A redirect with a request in flight moves to DROP
// so the stale response is swallowed when it arrives.
module fetch_queue
  import ppcpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          FQ_DEPTH = DEF_FQ_DEPTH,
  localparam int         CW       = $clog2(FQ_DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Redirect,
  input  logic [31:0]   RedirTarget,
  fetch_queue_if.master bus,
  output logic [CW-1:0] QCount
);

  logic [1:0]    r_state;
  logic          r_mem_req;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_fetch_pc;

  logic [31:0]   w_redir_pc;
  logic          w_push, w_pop;
  logic [CW-1:0] w_count;
  fq_entry_t     w_entry, w_head;
  logic          w_valid;

  assign w_redir_pc = {RedirTarget[31:2], 2'b00};
  assign w_push     = (r_state == S_WAIT) && bus.MemAck && !Redirect;
  assign w_pop      = w_valid && bus.D_Ready;
  assign w_entry    = '{pc: r_fetch_pc, pc4: pc_plus4(r_fetch_pc), inst: bus.MemData};

  fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (Redirect),
    .i_din   (w_entry),
    .o_head  (w_head),
    .o_valid (w_valid),
    .o_count (w_count)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_fetch_pc <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          // MemAck is ignored here; a redirect only retargets
          if (Redirect) begin
            r_fetch_pc <= w_redir_pc;
          end else if (w_count < CW'(FQ_DEPTH)) begin
            r_state    <= S_WAIT;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
          end
        end
        S_WAIT: begin
          if (bus.MemAck) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_fetch_pc <= Redirect ? w_redir_pc : pc_plus4(r_fetch_pc);
          end else if (Redirect) begin
            // Request cannot be retracted; keep MemReq up and drop the reply
            r_state    <= S_DROP;
            r_fetch_pc <= w_redir_pc;
          end
        end
        S_DROP: begin
          if (Redirect) r_fetch_pc <= w_redir_pc;
          if (bus.MemAck) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MemReq  = r_mem_req;
  assign bus.MemAddr = r_mem_addr;
  assign bus.F_Valid = w_valid;
  assign bus.F_PC    = w_head.pc;
  assign bus.F_PC4   = w_head.pc4;
  assign bus.F_Inst  = w_head.inst;
  assign QCount      = w_count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a small memory model
// that acks a configurable number of cycles after each request.
module tb_fetch_queue;
  import ppcpu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirTarget = '0;
  logic [2:0]  QCount;

  fetch_queue_if bus();

  fetch_queue #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(4)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Redirect    (Redirect),
    .RedirTarget (RedirTarget),
    .bus         (bus),
    .QCount      (QCount)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  int ack_dly = 1;
  int mcnt = 0;
  logic [31:0] alog[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Memory model: updates 1ns after each edge so the main sequence, which
  // samples 2ns after the edge, sees what the DUT will sample next edge.
  initial begin
    bus.MemAck  = 1'b0;
    bus.MemData = '0;
  end

  always begin
    @(posedge CLK or posedge RST);
    #1;
    if (RST) begin
      bus.MemAck = 1'b0;
      mcnt = 0;
    end else if (bus.MemAck) begin
      bus.MemAck = 1'b0;
      mcnt = 0;
    end else if (bus.MemReq) begin
      if (mcnt == ack_dly) begin
        bus.MemAck  = 1'b1;
        bus.MemData = memf(bus.MemAddr);
        alog.push_back(bus.MemAddr);
      end else begin
        mcnt++;
      end
    end else begin
      mcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    Redirect = 1'b0;
    bus.D_Ready = 1'b0;
    alog.delete();
    repeat (2) step();
    RST = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".MemReq"},  32'(bus.MemReq),  32'h0);
    chk({tag, ".MemAddr"}, bus.MemAddr,      32'h0);
    chk({tag, ".QCount"},  32'(QCount),      32'h0);
    chk({tag, ".F_Valid"}, 32'(bus.F_Valid), 32'h0);
    chk({tag, ".F_PC"},    bus.F_PC,         32'h0);
    chk({tag, ".F_PC4"},   bus.F_PC4,        32'h0);
    chk({tag, ".F_Inst"},  bus.F_Inst,       32'h0);
  endtask

  // Bounded wait for a valid head, then check its contents
  task automatic expect_head(input string tag, input logic [31:0] pc);
    for (int i = 0; i < 20 && !bus.F_Valid; i++) step();
    chk({tag, ".valid"}, 32'(bus.F_Valid), 32'h1);
    chk({tag, ".pc"},    bus.F_PC,         pc);
    chk({tag, ".pc4"},   bus.F_PC4,        pc + 32'd4);
    chk({tag, ".inst"},  bus.F_Inst,       memf(pc));
  endtask

  task automatic idle_redirect(input logic [31:0] tgt);
    do_reset();
    bus.D_Ready = 1'b1;
    ack_dly = 1;
    step();
    for (int i = 0; i < 20 && bus.MemReq; i++) step();
    Redirect = 1'b1;
    RedirTarget = tgt;
    step();
    Redirect = 1'b0;
  endtask

  initial begin
    bus.D_Ready = 1'b0;
    #1 RST = 1'b1;
    #1;
    chk_reset_outs("rst0");

    // Streaming fetch with decode always ready
    do_reset();
    bus.D_Ready = 1'b1;
    ack_dly = 1;
    step();
    chk("first.req",  32'(bus.MemReq), 32'h1);
    chk("first.addr", bus.MemAddr,     32'h0);
    for (int k = 0; k < 4; k++) begin
      expect_head("stream", 32'(4 * k));
      step();
    end
    for (int k = 0; k < 4; k++) chk("stream.addr", alog[k], 32'(4 * k));

    // Decode stalled: queue fills to 4 and fetching stops
    do_reset();
    ack_dly = 1;
    repeat (20) step();
    chk("full.count", 32'(QCount),      32'h4);
    chk("full.req",   32'(bus.MemReq),  32'h0);
    chk("full.acks",  32'(alog.size()), 32'h4);
    chk("full.head",  bus.F_PC,         32'h0);
    bus.D_Ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      expect_head("drain", 32'(4 * k));
      step();
    end

    // Redirect with request outstanding, ack two cycles later
    do_reset();
    bus.D_Ready = 1'b1;
    ack_dly = 2;
    step();
    chk("drop.req0", 32'(bus.MemReq), 32'h1);
    Redirect = 1'b1;
    RedirTarget = 32'h0000_0040;
    step();
    Redirect = 1'b0;
    chk("drop.count", 32'(QCount),      32'h0);
    chk("drop.valid", 32'(bus.F_Valid), 32'h0);
    chk("drop.hold",  32'(bus.MemReq),  32'h1);
    chk("drop.addr",  bus.MemAddr,      32'h0);
    step();
    step();
    chk("drop.idle",  32'(bus.MemReq),  32'h0);
    chk("drop.nopush", 32'(QCount),     32'h0);
    step();
    chk("drop.req1",  32'(bus.MemReq),  32'h1);
    chk("drop.tgt",   bus.MemAddr,      32'h0000_0040);
    expect_head("drop.head", 32'h0000_0040);

    // Redirect coinciding with MemAck and a pop
    do_reset();
    ack_dly = 1;
    for (int i = 0; i < 20 && QCount != 3'd1; i++) step();
    chk("same.count1", 32'(QCount), 32'h1);
    for (int i = 0; i < 20 && !bus.MemAck; i++) step();
    chk("same.ack",   32'(bus.MemAck),  32'h1);
    chk("same.valid", 32'(bus.F_Valid), 32'h1);
    Redirect = 1'b1;
    RedirTarget = 32'h0000_0100;
    bus.D_Ready = 1'b1;
    step();
    Redirect = 1'b0;
    bus.D_Ready = 1'b0;
    chk("same.count",  32'(QCount),      32'h0);
    chk("same.fvalid", 32'(bus.F_Valid), 32'h0);
    chk("same.idle",   32'(bus.MemReq),  32'h0);
    step();
    chk("same.req",  32'(bus.MemReq), 32'h1);
    chk("same.addr", bus.MemAddr,     32'h0000_0100);
    bus.D_Ready = 1'b1;
    expect_head("same.head", 32'h0000_0100);

    // Unaligned target is word aligned
    idle_redirect(32'h0000_0087);
    chk("align.idle",  32'(bus.MemReq), 32'h0);
    chk("align.count", 32'(QCount),     32'h0);
    step();
    chk("align.req",  32'(bus.MemReq), 32'h1);
    chk("align.addr", bus.MemAddr,     32'h0000_0084);
    expect_head("align.head", 32'h0000_0084);

    // Address wrap at top of memory
    idle_redirect(32'hFFFF_FFFC);
    step();
    chk("wrap.addr", bus.MemAddr, 32'hFFFF_FFFC);
    expect_head("wrap.head", 32'hFFFF_FFFC);
    chk("wrap.pc4", bus.F_PC4, 32'h0);
    step();
    chk("wrap.req",   32'(bus.MemReq), 32'h1);
    chk("wrap.naddr", bus.MemAddr,     32'h0);

    // Reset in WAIT with 3 entries queued
    do_reset();
    ack_dly = 1;
    for (int i = 0; i < 40 && !(QCount == 3'd3 && bus.MemReq); i++) step();
    chk("mid.count", 32'(QCount),     32'h3);
    chk("mid.req",   32'(bus.MemReq), 32'h1);
    chk("mid.addr",  bus.MemAddr,     32'h0000_000C);
    #1 RST = 1'b1;
    #1;
    chk_reset_outs("mid.rst");
    repeat (2) step();
    RST = 1'b0;
    step();
    chk("mid.rereq",  32'(bus.MemReq), 32'h1);
    chk("mid.readdr", bus.MemAddr,     32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have the parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have the parameter FQ_DEPTH, default 4, the queue entry count (power of two).
REQ-003 The block SHALL have the port CLK, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-004 The block SHALL have the port RST, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have the port Redirect, input, 1 bit: a branch or jump is taken; one-cycle pulse from the MEM stage PCsrc.
REQ-006 The block SHALL have the port RedirTarget, input, 32 bits: the new fetch address (Btarg or Jtarg).
REQ-007 The block SHALL have the port MemReq, output, 1 bit: an instruction-memory read request, held high until MemAck.
REQ-008 The block SHALL have the port MemAddr, output, 32 bits: the read address, word aligned.
REQ-009 The block SHALL have the port MemAck, input, 1 bit: a one-cycle pulse indicating that MemData is valid and the request is complete.
REQ-010 The block SHALL have the port MemData, input, 32 bits: the returned instruction word.
REQ-011 The block SHALL have the port F_Valid, output, 1 bit: the queue head is valid.
REQ-012 The block SHALL have the port F_PC, output, 32 bits: the head instruction address.
REQ-013 The block SHALL have the port F_PC4, output, 32 bits: the head address plus 4.
REQ-014 The block SHALL have the port F_Inst, output, 32 bits: the head instruction word, feeding the IF_ID register.
REQ-015 The block SHALL have the port D_Ready, input, 1 bit: the decode stage accepts the head this cycle.
REQ-016 The block SHALL have the port QCount, output, 3 bits: the number of occupied entries, 0..4.

Function
REQ-017 The controller SHALL implement three states: IDLE (no request), WAIT (MemReq=1, awaiting MemAck), and DROP (MemReq=1, response to be discarded).
REQ-018 In IDLE, the controller SHALL enter WAIT with MemAddr=FetchPC when QCount<FQ_DEPTH; otherwise it SHALL stay in IDLE. This reserves a slot for the returning word.
REQ-019 MemReq and MemAddr SHALL be registered, and SHALL be stable from the issue edge until the MemAck cycle inclusive.
REQ-020 When MemAck is high in WAIT and Redirect is low, the queue SHALL push {FetchPC, FetchPC+4, MemData}, FetchPC SHALL increment by 4, and the state SHALL go to IDLE. The next request SHALL appear no earlier than the cycle after the following edge, so one word is fetched per 2 cycles minimum.
REQ-021 FetchPC+4 SHALL use 32-bit modulo arithmetic: 32'hFFFF_FFFC wraps to 0.
REQ-022 A pop SHALL occur when F_Valid and D_Ready are both high. The head SHALL advance at the edge, and F_* SHALL be driven combinationally from the head entry.
REQ-023 A simultaneous push and pop SHALL leave QCount unchanged, with both operations performed.
REQ-024 A pop while the queue is empty SHALL be ignored. A push while the queue is full SHALL be impossible by construction (see REQ-018).
REQ-025 On Redirect, at the edge, the queue SHALL flush (QCount=0, F_Valid=0) and FetchPC SHALL load {RedirTarget[31:2], 2'b00}. Redirect SHALL override any pop or push in the same cycle.
REQ-026 On Redirect in WAIT without MemAck, the state SHALL go to DROP. MemReq SHALL stay high, since an issued request cannot be retracted.
REQ-027 On Redirect in WAIT with MemAck in the same cycle, the returned word SHALL be discarded and the state SHALL go to IDLE.
REQ-028 In DROP, MemAck SHALL discard the data and the state SHALL go to IDLE. A further Redirect while in DROP SHALL only reload FetchPC.
REQ-029 On Redirect in IDLE, the controller SHALL load FetchPC only. The next request SHALL use the new target.
REQ-030 The block SHALL ignore MemAck in IDLE.

Reset
REQ-031 While RST=1, the block SHALL asynchronously hold: state=IDLE, MemReq=0, MemAddr=0, FetchPC=RESET_PC, QCount=0, F_Valid=0, F_PC=0, F_PC4=0, F_Inst=0.
REQ-032 Reset asserted mid-request SHALL abandon the transaction, and the memory SHALL be reset by the same RST.
REQ-033 The first MemReq after reset SHALL rise on the first rising CLK edge after RST deasserts, with MemAddr=RESET_PC.

Structure
REQ-034 RESET_PC, FQ_DEPTH, and the state encodings (IDLE=2'd0, WAIT=2'd1, DROP=2'd2) SHALL reside in the shared ppcpu_pkg definitions file used by the pipeline.
REQ-035 Queue storage SHALL be the sub-module fetch_fifo: 4 entries of 96 bits, head/tail pointers, count, and push/pop/flush inputs.
REQ-036 The FSM, FetchPC, and the memory interface SHALL reside in fetch_queue.
REQ-037 The design SHALL contain no latches, and no combinational path from MemAck to MemReq.

Verification
REQ-038 The bench SHALL apply a reset release, memory acking 1 cycle after each request, with D_Ready=1, and SHALL observe MemAddr=0,4,8,C… and F_PC/F_Inst matching each word in order, with F_PC4=F_PC+4.
REQ-039 The bench SHALL hold D_Ready=0 with 6 memory words available, and SHALL observe QCount saturating at 4, MemReq staying 0 after the 4th ack, and no push lost.
REQ-040 The bench SHALL apply Redirect (RedirTarget=32'h0000_0040) with a request outstanding and MemAck 2 cycles later, and SHALL observe QCount=0 next cycle, the late word dropped, and the next MemAddr=32'h40.
REQ-041 The bench SHALL apply Redirect in the same cycle as MemAck and a pop, and SHALL observe the queue empty, the word not pushed, and the next request to the target.
REQ-042 The bench SHALL apply Redirect with RedirTarget=32'h0000_0087, and SHALL observe the next MemAddr=32'h0000_0084.
REQ-043 The bench SHALL fetch at FetchPC=32'hFFFF_FFFC, and SHALL observe F_PC4=0 and the next MemAddr=0.
REQ-044 The bench SHALL assert RST during WAIT with 3 entries queued, and SHALL observe all outputs immediately at reset values, then a fetch from RESET_PC after release.
